uid_allocator: RTL and testbench
================================

Name: uid_allocator

Overview:
- Hardware unique-ID source: keeps one incrementing ID counter per object type and returns the next ID for a requested type.
- Consumed by the stage that tags newly created transactions or objects with a per-type instance ID.
- Each type counts independently from 0, so the ID sequence is 0, 1, 2, ... per type.
- Request and response are valid/ready streams; one registered response stage; full throughput.

Parameters:
- NUM_TYPES, 8, number of independent ID sequences (≥2).
- TYPE_W, $clog2(NUM_TYPES), width of the type index (derived; do not override).
- UID_W, 16, ID width; MAX_UID = 2^UID_W-1.
- WRAP, 0, 0 = a type is exhausted after issuing MAX_UID; 1 = the counter wraps MAX_UID -> 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  allocation request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_type  in  TYPE_W  type index of the request.
- rsp_valid  out  1  response held valid until rsp_ready.
- rsp_ready  in  1  downstream accepts the response.
- rsp_type  out  TYPE_W  echo of req_type.
- rsp_uid  out  UID_W  allocated ID; 0 when exhausted or bad_type is set.
- rsp_exhausted  out  1  type exhausted; no ID was issued.
- rsp_bad_type  out  1  req_type ≥ NUM_TYPES; no ID was issued.
- clr_valid  in  1  clear a single type's sequence.
- clr_type  in  TYPE_W  type to clear.
- clr_all  in  1  clear every sequence.
- issued_total  out  32  count of successfully issued IDs; wraps modulo 2^32.

Behaviour:
- Per-type state:
  - cnt[t] (UID_W bits, next ID to issue).
  - done[t] (1 bit, exhausted flag; only used when WRAP=0).
- Reset (rst=1 at a clk edge): all cnt=0, done=0, rsp_valid=0, rsp_uid=0, rsp_type=0, rsp_exhausted=0, rsp_bad_type=0, issued_total=0. req_ready=1 in the first cycle after reset.
- req_ready = !rsp_valid || rsp_ready. It is combinational from rsp_ready; no other combinational input-to-output paths.
- Accept: on an edge with req_valid && req_ready, the response register loads. rsp_valid=1 from the next cycle, so latency is 1 cycle. Back-to-back accepts sustain one response per cycle while rsp_ready=1.
- Stall: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable and no counter changes from requests.
- Allocation for an accepted request of type t < NUM_TYPES:
  - done[t]=0: rsp_uid=cnt[t] and issued_total+=1.
    - If cnt[t]==MAX_UID: WRAP=1 sets cnt[t]=0; WRAP=0 sets done[t]=1 and cnt[t] holds.
    - Otherwise cnt[t]+=1.
  - done[t]=1: rsp_exhausted=1, rsp_uid=0, no state change.
- Bad type: t ≥ NUM_TYPES gives rsp_bad_type=1, rsp_uid=0, no state change. Only reachable when NUM_TYPES is not a power of 2.
- Clear:
  - clr_valid at an edge sets cnt[clr_type]=0, done[clr_type]=0.
  - clr_all sets all cnt=0, done=0.
  - A clr_type out of range is ignored.
  - Clears act regardless of handshake state.
  - issued_total is not cleared by clr; only rst clears it.
- Clear and accept in the same cycle on the same type: the response uses the pre-clear cnt/done. The clear wins the state update, so cnt=0 and done=0 after the edge.
- Clear and accept on different types: both take effect independently.
- Type independence: allocations on one type never change another type's cnt or done.
- Reset mid-operation: a pending response is dropped (rsp_valid=0). Requests presented while rst=1 are not accepted.
- All state updates occur only at clk edges. Outputs come straight from registers, except req_ready.

Test Plan:
- Sequence: after reset, 4 requests on type 2 with rsp_ready=1 -> rsp_uid 0,1,2,3 on 4 consecutive cycles. Types 0 and 1 then issue 0. issued_total=6.
- Interleave: types 3,5,3,5,3 -> uids 0,0,1,1,2 with matching rsp_type.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready=0 after the first accept, response held unchanged. No ID is skipped or duplicated after release.
- Exhaustion with UID_W=2, WRAP=0 -> 5 requests on type 1 give 0,1,2,3 then rsp_exhausted=1, uid 0. clr_type=1 then a request -> uid 0.
- Wrap with UID_W=2, WRAP=1 -> 6 requests give 0,1,2,3,0,1, never exhausted.
- Simultaneous clear and accept on type 4 with cnt=7 -> response uid 7, next request uid 0. Mid-stream rst -> rsp_valid=0 next cycle, first post-reset uid 0. Bad type 6 with NUM_TYPES=6 -> rsp_bad_type=1.

Source files
------------

// File: rtl/uid_allocator.sv
// uid_allocator
//   Hardware unique-ID source. Keeps one ID counter per object type and
//   hands out the next ID for the requested type. Each type counts on its own
//   from 0. Requests and responses are valid/ready streams with one
//   registered response stage, so a new request can be taken every cycle
//   while the consumer keeps up.
//
// Parameters
//   NUM_TYPES  number of independent ID sequences (>= 2)
//   TYPE_W     width of a type index, derived from NUM_TYPES
//   UID_W      ID width; the largest ID is 2^UID_W-1
//   WRAP       0: a type stops after issuing the largest ID
//              1: the counter rolls over to 0 instead
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid      allocation request
//   req_ready      request is taken when req_valid && req_ready
//   req_type       type index of the request
//   rsp_valid      response valid, held until rsp_ready
//   rsp_ready      downstream takes the response
//   rsp_type       echo of the request's type
//   rsp_uid        allocated ID (0 when nothing was issued)
//   rsp_exhausted  type has run out of IDs, nothing issued
//   rsp_bad_type   requested type does not exist, nothing issued
//   clr_valid      restart the sequence of clr_type
//   clr_type       type to restart
//   clr_all        restart every sequence
//   issued_total   running count of IDs actually issued (mod 2^32)

module uid_allocator #(
  parameter int NUM_TYPES = 8,
  parameter int TYPE_W    = $clog2(NUM_TYPES),
  parameter int UID_W     = 16,
  parameter bit WRAP      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TYPE_W-1:0] req_type,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TYPE_W-1:0] rsp_type,
  output logic [UID_W-1:0]  rsp_uid,
  output logic              rsp_exhausted,
  output logic              rsp_bad_type,
  input  logic              clr_valid,
  input  logic [TYPE_W-1:0] clr_type,
  input  logic              clr_all,
  output logic [31:0]       issued_total
);

  // One extra bit so NUM_TYPES itself is representable for the range check.
  localparam logic [TYPE_W:0]    TYPE_LIMIT = (TYPE_W + 1)'(NUM_TYPES);
  localparam logic [UID_W-1:0]   MAX_UID    = '1;
  localparam logic [UID_W-1:0]   UID_ONE    = {{(UID_W - 1){1'b0}}, 1'b1};
  localparam logic [31:0]        TOTAL_ONE  = 32'd1;

  // Per-type state: next ID to hand out, and the "ran out" flag.
  logic [UID_W-1:0]     cnt [NUM_TYPES];
  logic [NUM_TYPES-1:0] done;

  logic                 accept;
  logic                 type_ok;
  logic [TYPE_W-1:0]    sel_type;
  logic [UID_W-1:0]     sel_cnt;
  logic                 sel_done;
  logic                 issue_ok;
  logic [NUM_TYPES-1:0] alloc_hit;
  logic [NUM_TYPES-1:0] clr_hit;

  // The response register can take a new entry when it is empty or being
  // drained this cycle. This is the only combinational input-to-output path.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Look up the requested type's state. An out-of-range type is steered to
  // entry 0 so the lookup never indexes past the array; its result is
  // discarded anyway because type_ok is low.
  always_comb begin
    type_ok  = ({1'b0, req_type} < TYPE_LIMIT);
    sel_type = type_ok ? req_type : '0;
    sel_cnt  = cnt[sel_type];
    sel_done = done[sel_type];
    issue_ok = type_ok && !sel_done;
  end

  // Decode which types allocate and which get cleared this cycle. Decoding
  // against every in-range index also discards out-of-range clear types,
  // since no entry can match them.
  always_comb begin
    alloc_hit = '0;
    clr_hit   = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      alloc_hit[t] = accept && issue_ok && (req_type == TYPE_W'(t));
      clr_hit[t]   = clr_all || (clr_valid && (clr_type == TYPE_W'(t)));
    end
  end

  // Counter and exhaustion state. A clear takes priority over an allocation
  // to the same type; the response for that allocation was already built
  // from the pre-clear values, so the ID is still issued once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        cnt[t] <= '0;
      end
      done <= '0;
    end else begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        if (clr_hit[t]) begin
          cnt[t]  <= '0;
          done[t] <= 1'b0;
        end else if (alloc_hit[t]) begin
          if (cnt[t] == MAX_UID) begin
            // At the top of the range: roll over, or park on the last ID
            // and mark the type as used up.
            if (WRAP) begin
              cnt[t] <= '0;
            end else begin
              done[t] <= 1'b1;
            end
          end else begin
            cnt[t] <= cnt[t] + UID_ONE;
          end
        end
      end
    end
  end

  // Response register and issued-ID counter. A new entry loads on accept;
  // otherwise a consumed entry drops valid and a stalled entry holds all
  // its fields unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid     <= 1'b0;
      rsp_type      <= '0;
      rsp_uid       <= '0;
      rsp_exhausted <= 1'b0;
      rsp_bad_type  <= 1'b0;
      issued_total  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_type  <= req_type;
      if (!type_ok) begin
        rsp_uid       <= '0;
        rsp_exhausted <= 1'b0;
        rsp_bad_type  <= 1'b1;
      end else if (sel_done) begin
        rsp_uid       <= '0;
        rsp_exhausted <= 1'b1;
        rsp_bad_type  <= 1'b0;
      end else begin
        rsp_uid       <= sel_cnt;
        rsp_exhausted <= 1'b0;
        rsp_bad_type  <= 1'b0;
        issued_total  <= issued_total + TOTAL_ONE;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uid_allocator.sv
// tb_uid_allocator
//   Bench for uid_allocator. Three instances share clock and reset:
//     inst 0: defaults (8 types, 16-bit IDs, no wrap)
//     inst 1: 6 types, 2-bit IDs, no wrap (exhaustion and bad types)
//     inst 2: 8 types, 2-bit IDs, wrap
//   Requests push their expected response into a per-instance queue at the
//   accepting edge; a monitor pops and compares whenever a response is
//   consumed.

module tb_uid_allocator;

  localparam int NINST = 3;
  localparam int NVEC  = 26;

  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] uid;
    logic        exh;
    logic        bad;
  } rsp_t;

  typedef struct {
    int inst;
    int typ;
    int uid;
    bit exh;
    bit bad;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  // Stimulus, one slot per instance.
  logic       req_valid [NINST];
  logic [2:0] req_type  [NINST];
  logic       rsp_ready [NINST];
  logic       clr_valid [NINST];
  logic [2:0] clr_type  [NINST];
  logic       clr_all   [NINST];

  // Raw instance outputs.
  logic        a_req_ready, b_req_ready, c_req_ready;
  logic        a_rsp_valid, b_rsp_valid, c_rsp_valid;
  logic [2:0]  a_rsp_type,  b_rsp_type,  c_rsp_type;
  logic [15:0] a_rsp_uid;
  logic [1:0]  b_rsp_uid,   c_rsp_uid;
  logic        a_exh, b_exh, c_exh;
  logic        a_bad, b_bad, c_bad;
  logic [31:0] a_total, b_total, c_total;

  // Outputs gathered into arrays so tasks can address an instance by number.
  logic        req_ready_m [NINST];
  logic        rsp_valid_m [NINST];
  logic [2:0]  rsp_type_m  [NINST];
  logic [15:0] uid_m       [NINST];
  logic        exh_m       [NINST];
  logic        bad_m       [NINST];
  logic [31:0] total_m     [NINST];

  int checks = 0;
  int errors = 0;

  rsp_t exp_q [NINST][$];

  always #5 clk = ~clk;

  uid_allocator dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(a_req_ready), .req_type(req_type[0]),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready[0]), .rsp_type(a_rsp_type),
    .rsp_uid(a_rsp_uid), .rsp_exhausted(a_exh), .rsp_bad_type(a_bad),
    .clr_valid(clr_valid[0]), .clr_type(clr_type[0]), .clr_all(clr_all[0]),
    .issued_total(a_total)
  );

  uid_allocator #(.NUM_TYPES(6), .UID_W(2), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(b_req_ready), .req_type(req_type[1]),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready[1]), .rsp_type(b_rsp_type),
    .rsp_uid(b_rsp_uid), .rsp_exhausted(b_exh), .rsp_bad_type(b_bad),
    .clr_valid(clr_valid[1]), .clr_type(clr_type[1]), .clr_all(clr_all[1]),
    .issued_total(b_total)
  );

  uid_allocator #(.NUM_TYPES(8), .UID_W(2), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(c_req_ready), .req_type(req_type[2]),
    .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready[2]), .rsp_type(c_rsp_type),
    .rsp_uid(c_rsp_uid), .rsp_exhausted(c_exh), .rsp_bad_type(c_bad),
    .clr_valid(clr_valid[2]), .clr_type(clr_type[2]), .clr_all(clr_all[2]),
    .issued_total(c_total)
  );

  // Collect per-instance outputs into indexable arrays.
  always_comb begin
    req_ready_m[0] = a_req_ready;
    req_ready_m[1] = b_req_ready;
    req_ready_m[2] = c_req_ready;
    rsp_valid_m[0] = a_rsp_valid;
    rsp_valid_m[1] = b_rsp_valid;
    rsp_valid_m[2] = c_rsp_valid;
    rsp_type_m[0]  = a_rsp_type;
    rsp_type_m[1]  = b_rsp_type;
    rsp_type_m[2]  = c_rsp_type;
    uid_m[0]       = a_rsp_uid;
    uid_m[1]       = {14'd0, b_rsp_uid};
    uid_m[2]       = {14'd0, c_rsp_uid};
    exh_m[0]       = a_exh;
    exh_m[1]       = b_exh;
    exh_m[2]       = c_exh;
    bad_m[0]       = a_bad;
    bad_m[1]       = b_bad;
    bad_m[2]       = c_bad;
    total_m[0]     = a_total;
    total_m[1]     = b_total;
    total_m[2]     = c_total;
  end

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one request to instance k and wait (bounded) for the accepting
  // edge, then queue the expected response. With hold set, req_valid stays
  // high so the next call continues back-to-back.
  task automatic applyStimulus(input int k, input int t, input int uid,
                               input bit exh, input bit bad, input bit hold,
                               output int cycles);
    rsp_t e;
    bit   acc;
    req_valid[k] = 1'b1;
    req_type[k]  = 3'(t);
    acc    = 1'b0;
    cycles = 0;
    while (!acc && cycles < 20) begin
      @(negedge clk);
      acc = req_ready_m[k];
      @(posedge clk);
      cycles++;
    end
    #1;
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL accept_timeout[%0d]: got no accept in %0d cycles, expected accept", k, cycles);
    end else begin
      e.typ = 3'(t);
      e.uid = 16'(uid);
      e.exh = exh;
      e.bad = bad;
      exp_q[k].push_back(e);
    end
    if (!hold) req_valid[k] = 1'b0;
  endtask

  // Pulse a single-type or all-types clear for one edge.
  task automatic clearType(input int k, input int t, input bit all);
    clr_valid[k] = !all;
    clr_type[k]  = 3'(t);
    clr_all[k]   = all;
    @(posedge clk);
    #1;
    clr_valid[k] = 1'b0;
    clr_all[k]   = 1'b0;
  endtask

  // Scoreboard: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NINST; k++) begin
        if (rsp_valid_m[k] && rsp_ready[k]) begin
          rsp_t e;
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp[%0d]: got uid %0d, expected no response", k, uid_m[k]);
          end else begin
            e = exp_q[k].pop_front();
            checkOutput($sformatf("rsp_type[%0d]", k), 32'(rsp_type_m[k]), 32'(e.typ));
            checkOutput($sformatf("rsp_uid[%0d]", k), 32'(uid_m[k]), 32'(e.uid));
            checkOutput($sformatf("rsp_exhausted[%0d]", k), 32'(exh_m[k]), 32'(e.exh));
            checkOutput($sformatf("rsp_bad_type[%0d]", k), 32'(bad_m[k]), 32'(e.bad));
          end
        end
      end
    end
  end

  initial begin
    vec_t vecs [NVEC];
    int   cyc;
    bit   hold;
    int   w;

    vecs = '{
      // inst 0: four back-to-back on type 2, then types 0 and 1
      '{0, 2, 0, 1'b0, 1'b0}, '{0, 2, 1, 1'b0, 1'b0}, '{0, 2, 2, 1'b0, 1'b0},
      '{0, 2, 3, 1'b0, 1'b0}, '{0, 0, 0, 1'b0, 1'b0}, '{0, 1, 0, 1'b0, 1'b0},
      // inst 0: interleaved types 3 and 5
      '{0, 3, 0, 1'b0, 1'b0}, '{0, 5, 0, 1'b0, 1'b0}, '{0, 3, 1, 1'b0, 1'b0},
      '{0, 5, 1, 1'b0, 1'b0}, '{0, 3, 2, 1'b0, 1'b0},
      // inst 1: exhaust type 1, then out-of-range types, then type 5
      '{1, 1, 0, 1'b0, 1'b0}, '{1, 1, 1, 1'b0, 1'b0}, '{1, 1, 2, 1'b0, 1'b0},
      '{1, 1, 3, 1'b0, 1'b0}, '{1, 1, 0, 1'b1, 1'b0}, '{1, 1, 0, 1'b1, 1'b0},
      '{1, 6, 0, 1'b0, 1'b1}, '{1, 7, 0, 1'b0, 1'b1}, '{1, 5, 0, 1'b0, 1'b0},
      // inst 2: wrap-around
      '{2, 0, 0, 1'b0, 1'b0}, '{2, 0, 1, 1'b0, 1'b0}, '{2, 0, 2, 1'b0, 1'b0},
      '{2, 0, 3, 1'b0, 1'b0}, '{2, 0, 0, 1'b0, 1'b0}, '{2, 0, 1, 1'b0, 1'b0}
    };

    for (int k = 0; k < NINST; k++) begin
      req_valid[k] = 1'b0;
      req_type[k]  = 3'd0;
      rsp_ready[k] = 1'b1;
      clr_valid[k] = 1'b0;
      clr_type[k]  = 3'd0;
      clr_all[k]   = 1'b0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of every instance.
    @(negedge clk);
    for (int k = 0; k < NINST; k++) begin
      checkOutput($sformatf("reset_rsp_valid[%0d]", k), 32'(rsp_valid_m[k]), 32'd0);
      checkOutput($sformatf("reset_rsp_uid[%0d]", k), 32'(uid_m[k]), 32'd0);
      checkOutput($sformatf("reset_rsp_type[%0d]", k), 32'(rsp_type_m[k]), 32'd0);
      checkOutput($sformatf("reset_exh[%0d]", k), 32'(exh_m[k]), 32'd0);
      checkOutput($sformatf("reset_bad[%0d]", k), 32'(bad_m[k]), 32'd0);
      checkOutput($sformatf("reset_total[%0d]", k), total_m[k], 32'd0);
      checkOutput($sformatf("reset_req_ready[%0d]", k), 32'(req_ready_m[k]), 32'd1);
    end
    @(posedge clk);
    #1;

    // Vector table: back-to-back within an instance, one accept per cycle.
    for (int i = 0; i < NVEC; i++) begin
      hold = (i + 1 < NVEC) ? (vecs[i + 1].inst == vecs[i].inst) : 1'b0;
      applyStimulus(vecs[i].inst, vecs[i].typ, vecs[i].uid, vecs[i].exh,
                    vecs[i].bad, hold, cyc);
      checkOutput($sformatf("accept_cycles[%0d]", i), 32'(cyc), 32'd1);
    end
    @(negedge clk);
    checkOutput("total_after_table[0]", total_m[0], 32'd11);
    checkOutput("total_after_table[1]", total_m[1], 32'd5);
    checkOutput("total_after_table[2]", total_m[2], 32'd6);
    @(posedge clk);
    #1;

    // Backpressure on inst 0, type 6: the response must hold and nothing
    // else may be accepted while the consumer stalls.
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 6, 0, 1'b0, 1'b0, 1'b1, cyc);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_req_ready", 32'(a_req_ready), 32'd0);
      checkOutput("stall_rsp_valid", 32'(a_rsp_valid), 32'd1);
      checkOutput("stall_rsp_uid", 32'(a_rsp_uid), 32'd0);
      checkOutput("stall_rsp_type", 32'(a_rsp_type), 32'd6);
      checkOutput("stall_total", a_total, 32'd12);
      @(posedge clk);
      #1;
    end
    rsp_ready[0] = 1'b1;
    applyStimulus(0, 6, 1, 1'b0, 1'b0, 1'b1, cyc);
    checkOutput("release_cycles", 32'(cyc), 32'd1);
    applyStimulus(0, 6, 2, 1'b0, 1'b0, 1'b0, cyc);

    // Bring type 4 up to 7, then clear it on the same edge as a request.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 4, i, 1'b0, 1'b0, 1'b0, cyc);
    end
    clr_valid[0] = 1'b1;
    clr_type[0]  = 3'd4;
    applyStimulus(0, 4, 7, 1'b0, 1'b0, 1'b0, cyc);
    clr_valid[0] = 1'b0;
    applyStimulus(0, 4, 0, 1'b0, 1'b0, 1'b0, cyc);

    // Clear type 3 while type 5 allocates: both take effect.
    clr_valid[0] = 1'b1;
    clr_type[0]  = 3'd3;
    applyStimulus(0, 5, 2, 1'b0, 1'b0, 1'b0, cyc);
    clr_valid[0] = 1'b0;
    applyStimulus(0, 3, 0, 1'b0, 1'b0, 1'b0, cyc);
    applyStimulus(0, 5, 3, 1'b0, 1'b0, 1'b0, cyc);
    @(negedge clk);
    checkOutput("total_after_clears[0]", a_total, 32'd26);
    @(posedge clk);
    #1;

    // Inst 1: single clear revives the exhausted type, an out-of-range
    // clear does nothing, clr_all restarts everything.
    clearType(1, 1, 1'b0);
    applyStimulus(1, 1, 0, 1'b0, 1'b0, 1'b0, cyc);
    clearType(1, 7, 1'b0);
    applyStimulus(1, 1, 1, 1'b0, 1'b0, 1'b0, cyc);
    clearType(1, 0, 1'b1);
    applyStimulus(1, 5, 0, 1'b0, 1'b0, 1'b0, cyc);
    applyStimulus(1, 1, 0, 1'b0, 1'b0, 1'b0, cyc);
    @(negedge clk);
    checkOutput("total_after_clears[1]", b_total, 32'd9);
    repeat (3) @(posedge clk);
    #1;

    // Reset with a stalled response pending and a request still presented.
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 2, 4, 1'b0, 1'b0, 1'b1, cyc);
    rst = 1'b1;
    for (int k = 0; k < NINST; k++) exp_q[k].delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    checkOutput("midreset_total", a_total, 32'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    checkOutput("postreset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 2, 0, 1'b0, 1'b0, 1'b0, cyc);
    @(negedge clk);
    checkOutput("postreset_total", a_total, 32'd1);

    // Let any outstanding responses drain, bounded.
    w = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    for (int k = 0; k < NINST; k++) begin
      checkOutput($sformatf("queue_left[%0d]", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
